// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and widths.
package cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; only pointers and count are reset.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fetch_entry_t,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  T                 data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output T                 data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;
    logic             do_push;

    // Flush wins over both push and pop; a pop frees a slot for a push when full.
    always_comb begin
        do_pop  = pop_i & ~empty_o & ~flush_i;
        do_push = push_i & (~full_o | do_pop) & ~flush_i;
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_pop)  head_q <= head_q + PTR_W'(1);
            if (do_push) tail_q <= tail_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is not reset; empty masking keeps stale data off the output.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= data_i;
    end

    // Status and head presentation.
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == CNT_W'(DEPTH));
        count_o = count_q;
        data_o  = empty_o ? T'('0) : mem_q[head_q];
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, end-of-ROM stop flag and fetch-queue push control.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned FQ_DEPTH   = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [XLEN-1:0]    dec_pc,
    output logic               fetch_stopped
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic             stopped_q;
    logic             stopped_d;
    logic             push_c;
    logic             pop_c;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head_entry;
    logic             fq_full;
    logic             fq_empty;
    logic [CNT_W-1:0] fq_count;

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .T     (fetch_entry_t)
    ) u_fq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .data_i  (wr_entry),
        .pop_i   (pop_c),
        .flush_i (redirect_valid),
        .data_o  (head_entry),
        .full_o  (fq_full),
        .empty_o (fq_empty),
        .count_o (fq_count)
    );

    // Handshake and push qualification; redirect suppresses any push.
    always_comb begin
        pop_c          = dec_valid & dec_ready;
        push_c         = ~redirect_valid & ~stopped_q &
                         ((fq_count < CNT_W'(FQ_DEPTH)) | pop_c);
        wr_entry.pc    = pc_q;
        wr_entry.instr = imem_instr;
    end

    // Next PC: redirect first, else advance on push unless the next word would leave the ROM.
    always_comb begin
        pc_d      = pc_q;
        stopped_d = stopped_q;
        if (redirect_valid) begin
            pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
            stopped_d = 1'b0;
        end else if (push_c) begin
            if (pc_q + 32'd7 >= 32'(IMEM_BYTES)) begin
                stopped_d = 1'b1;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // PC and stop flag state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            stopped_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            stopped_q <= stopped_d;
        end
    end

    // Outputs straight from state; head data is already zeroed when empty.
    always_comb begin
        imem_addr     = pc_q;
        fetch_stopped = stopped_q;
        dec_valid     = ~fq_empty;
        dec_pc        = head_entry.pc;
        dec_instr     = head_entry.instr;
    end

    // Simulation checks on redirect targets and queue status consistency.
    always @(posedge clk) begin
        if (rst_n && redirect_valid) begin
            assert ((redirect_pc[1:0] == 2'b00) &&
                    ({1'b0, redirect_pc} + 33'd3 < 33'(IMEM_BYTES)))
            else $error("redirect_pc %h misaligned or beyond ROM", redirect_pc);
        end
        if (rst_n) begin
            assert (fq_full == (fq_count == CNT_W'(FQ_DEPTH)))
            else $error("fetch queue full flag inconsistent with count");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fetch_stopped;

    logic [31:0] rom [256];
    int          checks   = 0;
    int          failures = 0;

    // Reference model state
    fetch_entry_t mq[$];
    logic [31:0]  mpc;
    logic         mstop;

    fetch_unit #(.FQ_DEPTH(DEPTH), .RESET_PC(32'h0), .IMEM_BYTES(BYTES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fetch_stopped  (fetch_stopped)
    );

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the model says should be visible now.
    task automatic chk_model(input string tag);
        fetch_entry_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, "_valid"}, 32'(dec_valid), 32'(mq.size() > 0));
        chk({tag, "_pc"}, dec_pc, h.pc);
        chk({tag, "_instr"}, dec_instr, h.instr);
        chk({tag, "_addr"}, imem_addr, mpc);
        chk({tag, "_stop"}, 32'(fetch_stopped), 32'(mstop));
    endtask

    // Advance the model by one clock from the rules: redirect wins, else pop then push.
    task automatic model_clock();
        bit full_before;
        bit pop;
        full_before = (mq.size() >= DEPTH);
        pop = (mq.size() > 0) && dec_ready;
        if (redirect_valid) begin
            mq.delete();
            mpc   = {redirect_pc[31:2], 2'b00};
            mstop = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!mstop && (!full_before || pop)) begin
                mq.push_back('{pc: mpc, instr: rom[mpc >> 2]});
                if (mpc + 7 >= BYTES) mstop = 1'b1;
                else mpc = mpc + 4;
            end
        end
    endtask

    // One cycle: drive at negedge, check, clock, settle to the next negedge.
    task automatic step(input string tag, input bit rv, input logic [31:0] rpc, input bit rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        #1;
        chk_model(tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = (32'($urandom) & 32'hFFFF_FF00) | 32'(i);
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
        mq.delete(); mpc = 32'h0; mstop = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", 32'(dec_valid), 32'h0);
        chk("rst_pc", dec_pc, 32'h0);
        chk("rst_instr", dec_instr, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_stop", 32'(fetch_stopped), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: streaming with decode always ready
        for (int i = 0; i < 8; i++) step("t1", 1'b0, '0, 1'b1);
        // 2: stall until the queue saturates, then release
        for (int i = 0; i < 10; i++) step("t2_stall", 1'b0, '0, 1'b0);
        // 3: single pop while full, push in same cycle
        step("t3_pop", 1'b0, '0, 1'b1);
        step("t3_hold", 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step("t2_drain", 1'b0, '0, 1'b1);

        // 4: redirect with entries queued
        for (int i = 0; i < 3; i++) step("t4_fill", 1'b0, '0, 1'b0);
        step("t4_redir", 1'b1, 32'h40, 1'b1);
        chk("t4_flush_valid", 32'(dec_valid), 32'h0);
        step("t4_first", 1'b0, '0, 1'b1);
        chk("t4_first_pc", dec_pc, 32'h40);
        step("t4_second", 1'b0, '0, 1'b1);
        chk("t4_second_pc", dec_pc, 32'h44);

        // 5: run off the end of the ROM
        step("t5_redir", 1'b1, 32'h3F8, 1'b0);
        for (int i = 0; i < 4; i++) step("t5_stop", 1'b0, '0, 1'b0);
        chk("t5_stopped", 32'(fetch_stopped), 32'h1);
        chk("t5_addr", imem_addr, 32'h3FC);
        chk("t5_head", dec_pc, 32'h3F8);
        for (int i = 0; i < 3; i++) step("t5_drain", 1'b0, '0, 1'b1);
        chk("t5_drained", 32'(dec_valid), 32'h0);
        step("t5_restart", 1'b1, 32'h0, 1'b1);
        chk("t5_unstopped", 32'(fetch_stopped), 32'h0);

        // 6: asynchronous reset between edges
        for (int i = 0; i < 5; i++) step("t6_run", 1'b0, '0, 1'b0);
        @(posedge clk);
        model_clock();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(dec_valid), 32'h0);
        chk("t6_pc", dec_pc, 32'h0);
        chk("t6_instr", dec_instr, 32'h0);
        mq.delete(); mpc = 32'h0; mstop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_restart", 1'b0, '0, 1'b1);
        chk("t6_first_valid", 32'(dec_valid), 32'h1);
        chk("t6_first_pc", dec_pc, 32'h0);

        // Random phase: ready toggling and occasional redirects, some near the ROM end
        for (int i = 0; i < 400; i++) begin
            bit          rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 15) == 0);
            rpc = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 1) == 1) rpc = 32'h3E0 + (32'($urandom_range(0, 7)) << 2);
            step("rnd", rv, rpc, ($urandom_range(0, 3) != 0));
        end
        chk_model("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
